// File: rtl/johnson_seq_decoder.sv
// johnson_seq_decoder: decodes a sampled Johnson counter code to a phase and checks the shift sequence.
module johnson_seq_decoder #(
    parameter int N = 5,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W = 8,
    localparam int PW = $clog2(2 * N),
    localparam int CW = $clog2(LOCK_CNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     q_in,
    output logic [PW-1:0]    phase,
    output logic [2*N-1:0]   phase_oh,
    output logic             legal,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);
    typedef enum logic [1:0] {UNLOCK, TRACK, LOCKED} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [PW-1:0] exp_idx, exp_d, pc, idx, nxt;
    logic [N-1:0] low;
    logic is_legal, mismatch;
    // Folding the msb=1 half onto the msb=0 half: legal codes become a run of low ones.
    always_comb begin
        pc = '0;
        for (int i = 0; i < N; i++) pc = pc + PW'(q_in[i]);
        low = q_in[N-1] ? ~q_in : q_in;
        is_legal = (low & (low + N'(1))) == '0;
        idx = q_in[N-1] ? PW'(2 * N) - pc : pc;
        nxt = (idx == PW'(2 * N - 1)) ? '0 : idx + PW'(1);
    end
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        exp_d = exp_idx;
        mismatch = 1'b0;
        case (state)
            UNLOCK: begin
                if (is_legal) begin
                    state_d = TRACK;
                    cnt_d = CW'(1);
                    exp_d = nxt;
                end
            end
            TRACK: begin
                if (!is_legal) begin
                    state_d = UNLOCK;
                    cnt_d = '0;
                end else if (idx == exp_idx) begin
                    cnt_d = cnt + CW'(1);
                    exp_d = nxt;
                    if (cnt_d == CW'(LOCK_CNT)) state_d = LOCKED;
                end else begin
                    cnt_d = CW'(1);
                    exp_d = nxt;
                end
            end
            default: begin
                if (is_legal && idx == exp_idx) begin
                    exp_d = nxt;
                end else begin
                    mismatch = 1'b1;
                    state_d = is_legal ? TRACK : UNLOCK;
                    cnt_d = is_legal ? CW'(1) : '0;
                    exp_d = is_legal ? nxt : exp_idx;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNLOCK;
            cnt <= '0;
            exp_idx <= '0;
            phase <= '0;
            phase_oh <= '0;
            legal <= 1'b0;
            seq_err <= 1'b0;
            err_count <= '0;
        end else if (en) begin
            state <= state_d;
            cnt <= cnt_d;
            exp_idx <= exp_d;
            phase <= is_legal ? idx : phase;
            phase_oh <= is_legal ? (2 * N)'(1) << idx : '0;
            legal <= is_legal;
            seq_err <= mismatch;
            err_count <= (mismatch && err_count != '1) ? err_count + ERR_W'(1) : err_count;
        end else begin
            seq_err <= 1'b0;
        end
    end
    assign locked = state == LOCKED;
endmodule

// File: tb/tb_johnson_seq_decoder.sv
// tb_johnson_seq_decoder: table-driven vectors with a queue scoreboard; a second instance uses ERR_W=2.
module tb_johnson_seq_decoder;
    typedef struct {
        logic rst;
        logic en;
        logic [4:0] q;
        logic [3:0] ph;
        logic lg;
        logic lk;
        logic se;
    } vec_t;
    typedef struct {
        logic [3:0] ph;
        logic [9:0] oh;
        logic lg;
        logic lk;
        logic se;
        logic [7:0] ec;
        logic [1:0] ecb;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en;
    logic [4:0] q_in;
    logic [3:0] phase, phase_b;
    logic [9:0] phase_oh, phase_oh_b;
    logic legal, locked, seq_err, legal_b, locked_b, seq_err_b;
    logic [7:0] err_count;
    logic [1:0] err_count_b;
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    johnson_seq_decoder dut (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .phase(phase), .phase_oh(phase_oh),
        .legal(legal), .locked(locked), .seq_err(seq_err), .err_count(err_count)
    );
    johnson_seq_decoder #(.ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .phase(phase_b), .phase_oh(phase_oh_b),
        .legal(legal_b), .locked(locked_b), .seq_err(seq_err_b), .err_count(err_count_b)
    );

    function automatic vec_t v(logic r, logic e, logic [4:0] q, logic [3:0] ph, logic lg, logic lk, logic se);
        vec_t t;
        t.rst = r; t.en = e; t.q = q; t.ph = ph; t.lg = lg; t.lk = lk; t.se = se;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int ec = 0;
        exp_t x;
        tbl.push_back(v(1, 0, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 5'b00000, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b00001, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b00011, 2, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b00111, 3, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b01111, 4, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b11111, 5, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b11110, 6, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b11100, 7, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b11000, 8, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b10000, 9, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b00000, 0, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b00001, 1, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b00101, 1, 0, 0, 1));
        tbl.push_back(v(0, 1, 5'b00011, 2, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b00111, 3, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b01111, 4, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b11111, 5, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b11111, 5, 1, 0, 1));
        tbl.push_back(v(0, 1, 5'b11110, 6, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b11100, 7, 1, 1, 0));
        tbl.push_back(v(0, 0, 5'b10101, 7, 1, 1, 0));
        tbl.push_back(v(0, 0, 5'b11111, 7, 1, 1, 0));
        tbl.push_back(v(0, 0, 5'b00000, 7, 1, 1, 0));
        tbl.push_back(v(0, 0, 5'b01010, 7, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b11000, 8, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b10000, 9, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b00011, 2, 1, 0, 1));
        tbl.push_back(v(0, 1, 5'b00111, 3, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b01111, 4, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b01011, 4, 0, 0, 1));
        tbl.push_back(v(0, 1, 5'b00000, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b00001, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b00011, 2, 1, 1, 0));
        tbl.push_back(v(0, 1, 5'b00000, 0, 1, 0, 1));
        tbl.push_back(v(0, 1, 5'b00001, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b11111, 5, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b11110, 6, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b00000, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b10101, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 5'b00001, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b00011, 2, 1, 0, 0));
        tbl.push_back(v(1, 1, 5'b00111, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 5'b00111, 3, 1, 0, 0));
        tbl.push_back(v(0, 1, 5'b11011, 3, 0, 0, 0));
        tbl.push_back(v(0, 1, 5'b01000, 3, 0, 0, 0));
        rst = 1'b1;
        en = 1'b0;
        q_in = '0;
        for (int r = 0; r < tbl.size(); r++) begin
            rst = tbl[r].rst;
            en = tbl[r].en;
            q_in = tbl[r].q;
            if (tbl[r].rst) ec = 0;
            else if (tbl[r].en && tbl[r].se && ec < 255) ec++;
            x.ph = tbl[r].ph;
            x.oh = tbl[r].lg ? (10'd1 << tbl[r].ph) : 10'd0;
            x.lg = tbl[r].lg;
            x.lk = tbl[r].lk;
            x.se = tbl[r].se;
            x.ec = 8'(ec);
            x.ecb = (ec > 3) ? 2'd3 : 2'(ec);
            sb.push_back(x);
            @(posedge clk);
            #1;
            x = sb.pop_front();
            chk("phase", r, int'(phase), int'(x.ph));
            chk("phase_oh", r, int'(phase_oh), int'(x.oh));
            chk("legal", r, int'(legal), int'(x.lg));
            chk("locked", r, int'(locked), int'(x.lk));
            chk("seq_err", r, int'(seq_err), int'(x.se));
            chk("err_count", r, int'(err_count), int'(x.ec));
            chk("err_count_sat", r, int'(err_count_b), int'(x.ecb));
            chk("locked_b", r, int'(locked_b), int'(x.lk));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
